// File: rtl/q_bank.sv
// Writable question bank: stores (level, number, answer codes) entries and
// scans from a seed for the first valid, unissued entry of a requested level.
module q_bank #(
  parameter  int DEPTH   = 32,
  parameter  int LVL_W   = 2,
  parameter  int NUM_W   = 10,
  parameter  int FACT_N  = 3,
  parameter  int CODE_W  = 4,
  localparam int IDX_W   = $clog2(DEPTH),
  localparam int FACT_W  = FACT_N * CODE_W,
  localparam int ENTRY_W = LVL_W + NUM_W + FACT_W
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               WE,
  input  logic [IDX_W-1:0]   WADDR,
  input  logic [ENTRY_W-1:0] WDATA,
  input  logic               CLR_USED,
  input  logic               REQ,
  input  logic [LVL_W-1:0]   LEVEL_SEL,
  input  logic               LVL_ANY,
  input  logic [IDX_W-1:0]   SEED,
  output logic               BUSY,
  output logic               VALID,
  output logic               NONE,
  output logic [IDX_W-1:0]   Q_INDEX,
  output logic [LVL_W-1:0]   Q_LEVEL,
  output logic [NUM_W-1:0]   Q_NUM,
  output logic [FACT_W-1:0]  Q_FACT,
  output logic [IDX_W:0]     USED_CNT
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [IDX_W:0] LAST = (IDX_W+1)'(DEPTH - 1);

  logic [ENTRY_W-1:0] mem [DEPTH];

  state_t             state_q, state_d;
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [DEPTH-1:0]   used_q, used_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W:0]     cnt_q, cnt_d;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic               any_q, any_d;
  logic               valid_q, valid_d;
  logic               none_q, none_d;
  logic [IDX_W-1:0]   qidx_q, qidx_d;
  logic [LVL_W-1:0]   qlvl_q, qlvl_d;
  logic [NUM_W-1:0]   qnum_q, qnum_d;
  logic [FACT_W-1:0]  qfact_q, qfact_d;
  logic [IDX_W:0]     ucnt_q, ucnt_d;

  logic [ENTRY_W-1:0] ent;
  logic [LVL_W-1:0]   ent_lvl;
  logic [NUM_W-1:0]   ent_num;
  logic [FACT_W-1:0]  ent_fact;
  logic               hit;

  // Read sees pre-edge contents, so a same-edge write is judged on old data
  assign ent      = mem[ptr_q];
  assign ent_lvl  = ent[ENTRY_W-1 -: LVL_W];
  assign ent_num  = ent[FACT_W +: NUM_W];
  assign ent_fact = ent[FACT_W-1:0];
  assign hit      = vld_q[ptr_q] && !used_q[ptr_q] &&
                    (any_q || ent_lvl == lvl_q);

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    used_d  = used_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    any_d   = any_q;
    valid_d = 1'b0;
    none_d  = 1'b0;
    qidx_d  = qidx_q;
    qlvl_d  = qlvl_q;
    qnum_d  = qnum_q;
    qfact_d = qfact_q;
    unique case (state_q)
      IDLE: begin
        if (REQ) begin
          lvl_d   = LEVEL_SEL;
          any_d   = LVL_ANY;
          ptr_d   = SEED;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          qidx_d        = ptr_q;
          qlvl_d        = ent_lvl;
          qnum_d        = ent_num;
          qfact_d       = ent_fact;
          used_d[ptr_q] = 1'b1;
          valid_d       = 1'b1;
          state_d       = IDLE;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
          cnt_d = cnt_q + (IDX_W+1)'(1);
          if (cnt_q == LAST) begin
            none_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
    endcase
    if (WE) begin
      vld_d[WADDR]  = 1'b1;
      used_d[WADDR] = 1'b0;
    end
    // Clear has priority over a coinciding hit
    if (CLR_USED) used_d = '0;
  end

  always_comb begin
    ucnt_d = '0;
    for (int i = 0; i < DEPTH; i++)
      ucnt_d = ucnt_d + (IDX_W+1)'(used_q[i]);
  end

  always_ff @(posedge CLK) begin
    if (WE) mem[WADDR] <= WDATA;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      vld_q   <= '0;
      used_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      lvl_q   <= '0;
      any_q   <= 1'b0;
      valid_q <= 1'b0;
      none_q  <= 1'b0;
      qidx_q  <= '0;
      qlvl_q  <= '0;
      qnum_q  <= '0;
      qfact_q <= '0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      used_q  <= used_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      any_q   <= any_d;
      valid_q <= valid_d;
      none_q  <= none_d;
      qidx_q  <= qidx_d;
      qlvl_q  <= qlvl_d;
      qnum_q  <= qnum_d;
      qfact_q <= qfact_d;
      ucnt_q  <= ucnt_d;
    end
  end

  assign BUSY     = (state_q == SCAN);
  assign VALID    = valid_q;
  assign NONE     = none_q;
  assign Q_INDEX  = qidx_q;
  assign Q_LEVEL  = qlvl_q;
  assign Q_NUM    = qnum_q;
  assign Q_FACT   = qfact_q;
  assign USED_CNT = ucnt_q;

endmodule

// File: tb/tb_q_bank.sv
// Bench for q_bank: directed stimulus, a search-based reference model
// compared every cycle, and literal expectations for the key questions.
module tb_q_bank;
  localparam int DEPTH = 32;
  localparam int IDX_W = 5;
  localparam int LVL_W = 2;
  localparam int NUM_W = 10;
  localparam int FACT_W = 12;
  localparam int ENTRY_W = 24;

  logic               CLK = 1'b0;
  logic               RST_N = 1'b1;
  logic               WE = 1'b0;
  logic [IDX_W-1:0]   WADDR = '0;
  logic [ENTRY_W-1:0] WDATA = '0;
  logic               CLR_USED = 1'b0;
  logic               REQ = 1'b0;
  logic [LVL_W-1:0]   LEVEL_SEL = '0;
  logic               LVL_ANY = 1'b0;
  logic [IDX_W-1:0]   SEED = '0;
  logic               BUSY, VALID, NONE;
  logic [IDX_W-1:0]   Q_INDEX;
  logic [LVL_W-1:0]   Q_LEVEL;
  logic [NUM_W-1:0]   Q_NUM;
  logic [FACT_W-1:0]  Q_FACT;
  logic [IDX_W:0]     USED_CNT;

  q_bank dut (
    .CLK(CLK), .RST_N(RST_N), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .CLR_USED(CLR_USED), .REQ(REQ), .LEVEL_SEL(LEVEL_SEL),
    .LVL_ANY(LVL_ANY), .SEED(SEED), .BUSY(BUSY), .VALID(VALID),
    .NONE(NONE), .Q_INDEX(Q_INDEX), .Q_LEVEL(Q_LEVEL), .Q_NUM(Q_NUM),
    .Q_FACT(Q_FACT), .USED_CNT(USED_CNT)
  );

  always #5 CLK = ~CLK;

  int npass = 0;
  int ntotal = 0;
  bit chk_en = 1'b0;
  int cyc = 0;
  int e_cyc = 0;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input longint act,
                       input longint exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)",
                  name, act, exp, $time);
  endtask

  // Reference model: bank contents plus an outstanding-search record
  int  m_lvl [DEPTH];
  int  m_num [DEPTH];
  int  m_fact [DEPTH];
  bit  m_vld [DEPTH];
  bit  m_used [DEPTH];
  int  cd;
  bit  p_hit;
  int  p_idx;
  int  pc, si;
  bit  was_idle;
  int  exp_busy, exp_valid, exp_none;
  int  exp_qi, exp_ql, exp_qn, exp_qf, exp_ucnt;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_vld[i] = 1'b0;
        m_used[i] = 1'b0;
      end
      cd = 0; p_hit = 1'b0; p_idx = 0;
      exp_busy = 0; exp_valid = 0; exp_none = 0;
      exp_qi = 0; exp_ql = 0; exp_qn = 0; exp_qf = 0; exp_ucnt = 0;
    end else begin
      pc = 0;
      for (int i = 0; i < DEPTH; i++) pc += int'(m_used[i]);
      exp_ucnt = pc;
      exp_valid = 0;
      exp_none = 0;
      was_idle = (cd == 0);
      if (!was_idle) begin
        cd--;
        if (cd == 0) begin
          exp_busy = 0;
          if (p_hit) begin
            exp_valid = 1;
            exp_qi = p_idx;
            exp_ql = m_lvl[p_idx];
            exp_qn = m_num[p_idx];
            exp_qf = m_fact[p_idx];
            m_used[p_idx] = 1'b1;
          end else begin
            exp_none = 1;
          end
        end
      end
      if (WE) begin
        m_lvl[WADDR] = int'(WDATA[23:22]);
        m_num[WADDR] = int'(WDATA[21:12]);
        m_fact[WADDR] = int'(WDATA[11:0]);
        m_vld[WADDR] = 1'b1;
        m_used[WADDR] = 1'b0;
      end
      if (CLR_USED)
        for (int i = 0; i < DEPTH; i++) m_used[i] = 1'b0;
      if (was_idle && REQ) begin
        p_hit = 1'b0;
        cd = DEPTH;
        for (int k = 1; k <= DEPTH; k++) begin
          si = (int'(SEED) + k - 1) % DEPTH;
          if (!p_hit && m_vld[si] && !m_used[si] &&
              (LVL_ANY || m_lvl[si] == int'(LEVEL_SEL))) begin
            p_hit = 1'b1;
            p_idx = si;
            cd = k;
          end
        end
        exp_busy = 1;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("busy", BUSY, exp_busy);
      check("valid", VALID, exp_valid);
      check("none", NONE, exp_none);
      check("q_index", Q_INDEX, exp_qi);
      check("q_level", Q_LEVEL, exp_ql);
      check("q_num", Q_NUM, exp_qn);
      check("q_fact", Q_FACT, exp_qf);
      check("used_cnt", USED_CNT, exp_ucnt);
    end
  end

  task automatic wr(input int idx, input int lvl, input int num,
                    input int c0, input int c1, input int c2);
    @(posedge CLK); #1;
    WE = 1'b1;
    WADDR = IDX_W'(idx);
    WDATA = {LVL_W'(lvl), NUM_W'(num), 4'(c2), 4'(c1), 4'(c0)};
    @(posedge CLK); #1;
    WE = 1'b0;
  endtask

  task automatic start_req(input int lvl, input bit any, input int seed);
    @(posedge CLK); #1;
    REQ = 1'b1;
    LEVEL_SEL = LVL_W'(lvl);
    LVL_ANY = any;
    SEED = IDX_W'(seed);
    @(posedge CLK); #1;
    e_cyc = cyc;
    REQ = 1'b0;
  endtask

  task automatic wait_res(output int k, output bit v);
    bit done;
    done = 1'b0;
    k = -1;
    v = 1'b0;
    for (int j = 0; j < 40 && !done; j++) begin
      @(negedge CLK);
      if (VALID || NONE) begin
        done = 1'b1;
        v = VALID;
        k = cyc - e_cyc;
      end
    end
    if (!done) begin
      ntotal++;
      $display("FAIL result_timeout: got no VALID/NONE, required one");
    end
  endtask

  task automatic run_req(input string nm, input int lvl, input bit any,
                         input int seed, input int ek, input bit ev);
    int k;
    bit v;
    start_req(lvl, any, seed);
    wait_res(k, v);
    check({nm, "_edge"}, k, ek);
    check({nm, "_valid"}, v, ev);
  endtask

  int kk;
  bit vv;

  initial begin
    #2 RST_N = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_busy", BUSY, 0);
    check("rst_valid", VALID, 0);
    check("rst_qnum", Q_NUM, 0);
    check("rst_ucnt", USED_CNT, 0);
    @(posedge CLK); #1 RST_N = 1'b1;

    wr(0, 0, 30, 1, 2, 3);
    wr(1, 0, 66, 1, 2, 5);
    wr(2, 1, 42, 1, 2, 4);
    wr(3, 1, 75, 2, 3, 3);
    wr(4, 2, 102, 7, 2, 1);
    wr(5, 3, 874, 9, 8, 1);

    run_req("lvl1_a", 1, 0, 0, 3, 1);
    check("lvl1_a_idx", Q_INDEX, 2);
    check("lvl1_a_num", Q_NUM, 42);
    check("lvl1_a_fact", Q_FACT, 12'h421);
    @(negedge CLK);
    check("lvl1_a_ucnt", USED_CNT, 1);

    run_req("lvl1_b", 1, 0, 0, 4, 1);
    check("lvl1_b_idx", Q_INDEX, 3);
    check("lvl1_b_num", Q_NUM, 75);

    run_req("lvl1_c", 1, 0, 0, 32, 0);
    check("lvl1_c_num", Q_NUM, 75);

    @(posedge CLK); #1 CLR_USED = 1'b1;
    @(posedge CLK); #1 CLR_USED = 1'b0;
    run_req("clr_seed3", 1, 0, 3, 1, 1);
    check("clr_seed3_idx", Q_INDEX, 3);
    @(negedge CLK);
    check("clr_seed3_ucnt", USED_CNT, 1);

    run_req("wrap", 0, 0, 30, 3, 1);
    check("wrap_idx", Q_INDEX, 0);
    check("wrap_num", Q_NUM, 30);

    run_req("any", 0, 1, 4, 1, 1);
    check("any_idx", Q_INDEX, 4);
    check("any_num", Q_NUM, 102);

    // Second REQ during a long miss scan must be dropped
    start_req(2, 0, 5);
    repeat (4) @(posedge CLK);
    #1 REQ = 1'b1; LVL_ANY = 1'b1; SEED = '0;
    @(posedge CLK); #1 REQ = 1'b0; LVL_ANY = 1'b0;
    wait_res(kk, vv);
    check("busy_req_edge", kk, 32);
    check("busy_req_valid", vv, 0);
    repeat (6) @(negedge CLK);
    check("busy_req_dropped", VALID, 0);

    start_req(3, 0, 5);
    WE = 1'b1;
    WADDR = IDX_W'(5);
    WDATA = {2'd0, 10'd874, 4'd1, 4'd8, 4'd9};
    @(posedge CLK); #1 WE = 1'b0;
    wait_res(kk, vv);
    check("same_edge_edge", kk, 1);
    check("same_edge_valid", vv, 1);
    check("same_edge_num", Q_NUM, 874);
    check("same_edge_fact", Q_FACT, 12'h189);
    run_req("lvl3_gone", 3, 0, 0, 32, 0);

    start_req(3, 0, 0);
    repeat (4) @(posedge CLK);
    #1 RST_N = 1'b0;
    #1;
    check("scan_rst_busy", BUSY, 0);
    check("scan_rst_valid", VALID, 0);
    repeat (2) @(negedge CLK);
    check("scan_rst_qnum", Q_NUM, 0);
    @(posedge CLK); #1 RST_N = 1'b1;
    run_req("post_rst", 3, 0, 0, 32, 0);
    check("post_rst_ucnt", USED_CNT, 0);

    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/q_bank.md
# q_bank

Parametrised, writable question bank for the factorisation game. Each entry holds a difficulty level, the number to factor and a fixed-length list of prime-index answer codes. On request, the block scans the bank from a caller-supplied seed and returns the first valid, not-yet-issued entry of the requested level. It sits between the random/level-select logic and the input and check modules, replacing the fixed read-only question table.

## Interface
- DEPTH, 32, number of entries; power of two, ≥2; IDX_W = log2(DEPTH)
- LVL_W, 2, level field width
- NUM_W, 10, question number width
- FACT_N, 3, answer code slots per entry
- CODE_W, 4, answer code width; code 0 = empty slot, 1..9 = primes 2,3,5,7,11,13,17,19,23
- ENTRY_W, LVL_W+NUM_W+FACT_N*CODE_W (24), derived
- CLK  in  1  single clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- WE  in  1  write strobe
- WADDR  in  IDX_W  write index
- WDATA  in  ENTRY_W  {level, number, fact[FACT_N-1] … fact[0]}
- CLR_USED  in  1  clears all issued marks
- REQ  in  1  request pulse; sampled only when BUSY=0
- LEVEL_SEL  in  LVL_W  requested level
- LVL_ANY  in  1  when high, any level matches
- SEED  in  IDX_W  first index to examine
- BUSY  out  1  scan in progress
- VALID  out  1  one-cycle pulse; Q_* outputs hold a new question
- NONE  out  1  one-cycle pulse; no matching entry found
- Q_INDEX  out  IDX_W  index of the issued entry
- Q_LEVEL  out  LVL_W, Q_NUM  out  NUM_W, Q_FACT  out  FACT_N*CODE_W  issued entry fields
- USED_CNT  out  IDX_W+1  number of entries currently marked issued

## Operation
- Storage: DEPTH×ENTRY_W array, plus per-entry `vld` and `used` bits.
- Write: on WE, the data is stored, `vld[WADDR]` is set and `used[WADDR]` is cleared. Writes are accepted in any state.
- States: IDLE and SCAN.
  - In IDLE, REQ=1 latches LEVEL_SEL, LVL_ANY and SEED. The pointer is set to SEED, the counter to 0, and the state moves to SCAN.
  - In SCAN, one entry is examined per cycle at the pointer. A hit requires vld=1, used=0, and (LVL_ANY or level==latched level).
  - On a hit: load the Q_* outputs, set `used`, pulse VALID, return to IDLE.
  - On a miss: the pointer increments mod DEPTH (DEPTH-1 wraps to 0) and the counter increments. If the counter reaches DEPTH, pulse NONE, leave Q_* unchanged and return to IDLE.
- REQ while BUSY=1 is ignored and is not queued.
- An entry written on the same edge it is examined is judged on its old contents; the new contents apply afterwards.
- CLR_USED clears all `used` bits. If it coincides with a hit, the clear wins and the hit entry stays unused. VALID is still issued.
- USED_CNT is the population count of `used`, registered.

## Timing
- Reset (async assert, sync release): state IDLE, all `vld` and `used` bits 0, BUSY=0, VALID=0, NONE=0, Q_INDEX=0, Q_LEVEL=0, Q_NUM=0, Q_FACT=0, USED_CNT=0. Array data is not reset.
- Reset during SCAN aborts the scan; no VALID or NONE is produced.
- Scan timing: REQ sampled at edge e. The k-th entry examined (k=1..DEPTH) is evaluated at edge e+k.
  - On a hit, VALID is high for the cycle after edge e+k, with Q_* valid from that edge on.
  - Worst-case NONE is at edge e+DEPTH.
- BUSY is high from edge e to the result edge and is low in the VALID/NONE cycle, so a new REQ may be sampled in that cycle.
- Q_* outputs hold their values until the next VALID.
- USED_CNT reflects a set or clear one edge after it occurs.

## Test plan
- Load entries 0..5 as (lvl,num,codes): (0,30,1/2/3), (0,66,1/2/5), (1,42,1/2/4), (1,75,2/3/3), (2,102,7/2/1), (3,874,9/8/1). Then REQ LEVEL_SEL=1, SEED=0 → VALID at edge e+3, Q_INDEX=2, Q_NUM=42, Q_FACT=0x421, USED_CNT=1.
- Repeat REQ LEVEL_SEL=1, SEED=0 → Q_INDEX=3, Q_NUM=75 at e+4. A third identical REQ → NONE at e+32, VALID stays 0, Q_NUM stays 75.
- Pulse CLR_USED, then REQ level 1, SEED=3 → Q_INDEX=3 at e+1, USED_CNT=1. REQ level 0, SEED=30 → wraps 30,31,0 → Q_INDEX=0, Q_NUM=30 at e+3.
- REQ LVL_ANY=1, SEED=4 → Q_INDEX=4, Q_NUM=102 at e+1. A REQ pulsed while BUSY=1 during a long scan produces no second result.
- Same-edge write: REQ level 3, SEED=5, with WE to WADDR=5 carrying level 0 on edge e+1 → hit on old data, Q_NUM=874. The next level-3 REQ → NONE.
- Assert RST_N=0 five cycles into a scan → BUSY=0 and no VALID. After release, REQ level 3 → NONE at e+32, since all `vld` bits are cleared.
